mul_unit: RTL

Pipelined integer multiply functional unit in the execution stage, directly downstream of the issue stage. It accepts an operation when the issue stage raises its multiply-select strobe, carries the destination tag alongside the operands, and presents the result to the writeback stage after a fixed latency. Writeback backpressure stalls the pipeline. The block reports occupancy so issue can stall instead of over-issuing.

---
 rtl/oc2_pkg.sv | 34 +++
 rtl/mul_unit_if.sv | 44 ++++
 rtl/mul_pipe_slot.sv | 30 +++
 rtl/mul_unit.sv | 113 +++++++++++
 4 files changed

// File: rtl/oc2_pkg.sv
// Shared execution-stage definitions: functional-unit codes, widths, multiply helpers.
package oc2_pkg;

    typedef enum logic [1:0] {
        FU_ALU_MISC = 2'b00,
        FU_MEM      = 2'b01,
        FU_MULT     = 2'b10,
        FU_NONE     = 2'b11
    } fu_e;

    localparam int unsigned TAG_W      = 5;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned MUL_STAGES = 4;

    // Control that travels with a multiply from issue to writeback.
    typedef struct packed {
        logic [TAG_W-1:0] regdest;
        logic             writereg;
    } mul_ctrl_t;

    // Extending both operands to 64 bits makes one 64-bit multiply correct for signed and unsigned.
    function automatic logic [2*DATA_W-1:0] mul_product(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic              unsig
    );
        logic [2*DATA_W-1:0] ea;
        logic [2*DATA_W-1:0] eb;
        ea = {{DATA_W{~unsig & a[DATA_W-1]}}, a};
        eb = {{DATA_W{~unsig & b[DATA_W-1]}}, b};
        return ea * eb;
    endfunction

endpackage

// File: rtl/mul_unit_if.sv
// Issue/writeback bundle of the multiply unit; HI/LO signals exist only with MUL_HILO_EN.
interface mul_unit_if;

    logic                         iss_mul_oper;
    logic [oc2_pkg::DATA_W-1:0]   iss_ex_rega;
    logic [oc2_pkg::DATA_W-1:0]   iss_ex_regb;
    logic                         iss_ex_unsig;
    logic [oc2_pkg::TAG_W-1:0]    iss_ex_regdest;
    logic                         iss_ex_writereg;
    logic                         mul_ready;
    logic [3:0]                   mul_inflight;
    logic                         mul_wb_valid;
    logic [oc2_pkg::DATA_W-1:0]   mul_wb_data;
    logic [oc2_pkg::TAG_W-1:0]    mul_wb_regdest;
    logic                         mul_wb_writereg;
    logic                         wb_mul_ready;
`ifdef MUL_HILO_EN
    logic [oc2_pkg::DATA_W-1:0]   mul_hi;
    logic [oc2_pkg::DATA_W-1:0]   mul_lo;
`endif

    // Issue and writeback side.
    modport master (
        output iss_mul_oper, iss_ex_rega, iss_ex_regb, iss_ex_unsig,
               iss_ex_regdest, iss_ex_writereg, wb_mul_ready,
        input  mul_ready, mul_inflight, mul_wb_valid, mul_wb_data,
               mul_wb_regdest, mul_wb_writereg
`ifdef MUL_HILO_EN
        , input mul_hi, mul_lo
`endif
    );

    // Multiply unit side.
    modport slave (
        input  iss_mul_oper, iss_ex_rega, iss_ex_regb, iss_ex_unsig,
               iss_ex_regdest, iss_ex_writereg, wb_mul_ready,
        output mul_ready, mul_inflight, mul_wb_valid, mul_wb_data,
               mul_wb_regdest, mul_wb_writereg
`ifdef MUL_HILO_EN
        , output mul_hi, mul_lo
`endif
    );

endinterface

// File: rtl/mul_pipe_slot.sv
// One multiply pipeline slot: valid, control and a data payload, frozen when en is low.
module mul_pipe_slot
    import oc2_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          en,
    input  logic          valid_d,
    input  mul_ctrl_t     ctrl_d,
    input  logic [DW-1:0] data_d,
    output logic          valid_q,
    output mul_ctrl_t     ctrl_q,
    output logic [DW-1:0] data_q
);

    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else if (en) begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/mul_unit.sv
// Pipelined 32x32 integer multiply unit with writeback backpressure.
// Define MUL_HILO_EN to carry the full 64-bit product and keep HI/LO registers.
module mul_unit
    import oc2_pkg::*;
#(
    parameter int unsigned STAGES = MUL_STAGES
) (
    input  logic       clock,
    input  logic       reset,
    mul_unit_if.slave  bus
);

    localparam int unsigned OPW = 2 * DATA_W + 1;
`ifdef MUL_HILO_EN
    localparam int unsigned PRW = 2 * DATA_W;
`else
    localparam int unsigned PRW = DATA_W;
`endif

    if (STAGES < 2 || STAGES > 8) begin : g_bad_stages
        $error("mul_unit: STAGES must be in 2..8");
    end

    logic            hold;
    logic            accept;
    logic            retire;
    logic            en;

    logic            valid_q [STAGES];
    mul_ctrl_t       ctrl_q  [STAGES];
    logic [OPW-1:0]  op_q;
    logic [PRW-1:0]  prod_q  [STAGES-1];
    logic [3:0]      inflight_q;

    assign hold   = valid_q[STAGES-1] && !bus.wb_mul_ready;
    assign en     = !hold;
    assign accept = bus.iss_mul_oper && !hold;
    assign retire = valid_q[STAGES-1] && bus.wb_mul_ready;

    // Slot 0 latches {unsig, a, b}; the product is formed entering slot 1 and then just carried.
    mul_pipe_slot #(.DW(OPW)) u_slot0 (
        .clock   (clock),
        .reset   (reset),
        .en      (en),
        .valid_d (bus.iss_mul_oper),
        .ctrl_d  ('{regdest: bus.iss_ex_regdest, writereg: bus.iss_ex_writereg}),
        .data_d  ({bus.iss_ex_unsig, bus.iss_ex_rega, bus.iss_ex_regb}),
        .valid_q (valid_q[0]),
        .ctrl_q  (ctrl_q[0]),
        .data_q  (op_q)
    );

    for (genvar i = 1; i < STAGES; i++) begin : g_slot
        logic [PRW-1:0] data_d;

        if (i == 1) begin : g_mul
            assign data_d = PRW'(mul_product(op_q[2*DATA_W-1:DATA_W], op_q[DATA_W-1:0],
                                             op_q[2*DATA_W]));
        end else begin : g_carry
            assign data_d = prod_q[i-2];
        end

        mul_pipe_slot #(.DW(PRW)) u_slot (
            .clock   (clock),
            .reset   (reset),
            .en      (en),
            .valid_d (valid_q[i-1]),
            .ctrl_d  (ctrl_q[i-1]),
            .data_d  (data_d),
            .valid_q (valid_q[i]),
            .ctrl_q  (ctrl_q[i]),
            .data_q  (prod_q[i-1])
        );
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            inflight_q <= '0;
        end else begin
            case ({accept, retire})
                2'b10:   inflight_q <= inflight_q + 4'd1;
                2'b01:   inflight_q <= inflight_q - 4'd1;
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    assign bus.mul_ready       = !hold;
    assign bus.mul_inflight    = inflight_q;
    assign bus.mul_wb_valid    = valid_q[STAGES-1];
    assign bus.mul_wb_data     = prod_q[STAGES-2][DATA_W-1:0];
    assign bus.mul_wb_regdest  = ctrl_q[STAGES-1].regdest;
    assign bus.mul_wb_writereg = ctrl_q[STAGES-1].writereg;

`ifdef MUL_HILO_EN
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (retire) begin
            hi_q <= prod_q[STAGES-2][2*DATA_W-1:DATA_W];
            lo_q <= prod_q[STAGES-2][DATA_W-1:0];
        end
    end

    assign bus.mul_hi = hi_q;
    assign bus.mul_lo = lo_q;
`endif

endmodule
